mux_channel_scanner: RTL and testbench

Sequencer that sits directly upstream and downstream of the team's 4:1 multiplexer. It drives the mux select lines address0/address1 and reads the mux output back. On a start request it steps through all four channels, holding each select for a programmable settle time to cover the gate-level mux delay. It captures one bit per channel and presents the 4-bit snapshot on a valid/ready output handshake.

---
 rtl/mux_channel_scanner_if.sv | 22 ++
 rtl/mux_channel_scanner.sv | 106 ++++++++++
 tb/tb_mux_channel_scanner.sv | 211 +++++++++++++++++++++
 3 files changed

// File: rtl/mux_channel_scanner_if.sv
// Handshake and mux-facing signals of the channel scanner.
// The master side is the scanner; the slave side is the mux and the data consumer.
interface mux_channel_scanner_if;
  logic       start;
  logic       mux_out;
  logic       address0;
  logic       address1;
  logic [3:0] data;
  logic       valid;
  logic       ready;
  logic       busy;

  modport master (
    input  start, mux_out, ready,
    output address0, address1, data, valid, busy
  );

  modport slave (
    output start, mux_out, ready,
    input  address0, address1, data, valid, busy
  );
endinterface

// File: rtl/mux_channel_scanner.sv
// Steps a 4:1 mux through its channels, holds each select for a settle time,
// captures one bit per channel and offers the snapshot on valid/ready.
module mux_channel_scanner #(
  parameter int unsigned SETTLE_CYCLES = 2,
  parameter bit          CONTINUOUS    = 1'b0
) (
  input  logic                   clk,
  input  logic                   reset_n,
  mux_channel_scanner_if.master  bus
);

  typedef enum logic [1:0] {IDLE, SETTLE, CAPTURE, DONE} state_t;

  localparam logic [3:0] CNT_LAST = 4'(SETTLE_CYCLES - 1);

  state_t     state_q, state_d;
  logic [1:0] ch_q, ch_d;
  logic [3:0] cnt_q, cnt_d;
  logic [3:0] sample_q, sample_d;
  logic [3:0] data_q, data_d;
  logic       valid_q, valid_d;
  logic       busy_q, busy_d;
  logic       go;

  assign go = bus.start | CONTINUOUS;

  // ch_q doubles as the select register: it is forced to 0 outside a scan.
  always_comb begin
    state_d  = state_q;
    ch_d     = ch_q;
    cnt_d    = cnt_q;
    sample_d = sample_q;
    data_d   = data_q;
    valid_d  = valid_q;
    busy_d   = busy_q;
    case (state_q)
      IDLE: begin
        if (go) begin
          ch_d    = '0;
          cnt_d   = '0;
          busy_d  = 1'b1;
          state_d = SETTLE;
        end
      end
      SETTLE: begin
        cnt_d = cnt_q + 4'd1;
        if (cnt_q == CNT_LAST) state_d = CAPTURE;
      end
      CAPTURE: begin
        sample_d[ch_q] = bus.mux_out;
        if (ch_q != 2'd3) begin
          ch_d    = ch_q + 2'd1;
          cnt_d   = '0;
          state_d = SETTLE;
        end else begin
          data_d  = sample_d;
          valid_d = 1'b1;
          busy_d  = 1'b0;
          ch_d    = '0;
          state_d = DONE;
        end
      end
      DONE: begin
        if (bus.ready) begin
          valid_d = 1'b0;
          if (go) begin
            ch_d    = '0;
            cnt_d   = '0;
            busy_d  = 1'b1;
            state_d = SETTLE;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= IDLE;
      ch_q     <= '0;
      cnt_q    <= '0;
      sample_q <= '0;
      data_q   <= '0;
      valid_q  <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      ch_q     <= ch_d;
      cnt_q    <= cnt_d;
      sample_q <= sample_d;
      data_q   <= data_d;
      valid_q  <= valid_d;
      busy_q   <= busy_d;
    end
  end

  assign bus.address0 = ch_q[0];
  assign bus.address1 = ch_q[1];
  assign bus.data     = data_q;
  assign bus.valid    = valid_q;
  assign bus.busy     = busy_q;

endmodule

// File: tb/tb_mux_channel_scanner.sv
// Scoreboard bench: the driver pushes the expected snapshot and valid edge per scan,
// monitors pop and compare when the scanners present valid.
module tb_mux_channel_scanner;

  localparam int S     = 2;
  localparam int SCAN  = 4 * (S + 1);
  localparam int S2    = 1;
  localparam int SCAN2 = 4 * (S2 + 1);

  typedef struct {
    logic [3:0] data;
    int         edge_n;
  } exp_t;

  logic clk = 1'b0;
  logic reset_n = 1'b1;
  always #80 clk = ~clk;

  mux_channel_scanner_if bus();
  mux_channel_scanner_if bus2();

  mux_channel_scanner #(.SETTLE_CYCLES(S), .CONTINUOUS(1'b0)) dut (
    .clk(clk), .reset_n(reset_n), .bus(bus)
  );
  mux_channel_scanner #(.SETTLE_CYCLES(S2), .CONTINUOUS(1'b0)) dut2 (
    .clk(clk), .reset_n(reset_n), .bus(bus2)
  );

  // Ideal mux for the main scanner, 150-unit propagation mux for the second one.
  logic [3:0] in_vec, in2;
  logic [1:0] sel, sel2;
  logic       mux2_out;
  assign sel  = {bus.address1, bus.address0};
  assign sel2 = {bus2.address1, bus2.address0};
  assign bus.mux_out = in_vec[sel];
  always @(sel2 or in2) mux2_out <= #150 in2[sel2];
  assign bus2.mux_out = mux2_out;

  int   cyc = 0;
  always @(posedge clk) cyc++;

  int   compared = 0;
  int   mismatched = 0;
  exp_t q1[$];
  exp_t q2[$];
  bit   chained = 1'b0;

  function automatic void check(input string name, input int act, input int exp);
    compared++;
    if (act != exp) begin
      mismatched++;
      $display("FAIL %s: got %0d (0x%0h) required %0d (0x%0h) at edge %0d", name, act, act, exp, exp, cyc);
    end
  endfunction

  // Main scanner monitor.
  exp_t cur1;
  bit   have1 = 1'b0, v1_prev = 1'b0, hs1_prev = 1'b0;
  always begin
    @(negedge clk);
    #20;
    if (!reset_n) begin
      v1_prev = 1'b0; hs1_prev = 1'b0; have1 = 1'b0;
    end else begin
      if (v1_prev) check("valid_hold", int'(bus.valid), hs1_prev ? 0 : 1);
      if (bus.valid && !v1_prev) begin
        if (q1.size() == 0) begin
          compared++; mismatched++; have1 = 1'b0;
          $display("FAIL unexpected_valid: got valid=1 data=%b, required valid=0 (no scan pending) at edge %0d", bus.data, cyc);
        end else begin
          cur1 = q1.pop_front();
          have1 = 1'b1;
          check("valid_edge", cyc, cur1.edge_n);
        end
      end
      if (bus.valid && have1) check("data", int'(bus.data), int'(cur1.data));
      hs1_prev = bus.valid && bus.ready;
      v1_prev  = bus.valid;
    end
  end

  // Gate-delay scanner monitor; its consumer is always ready.
  exp_t cur2;
  always begin
    @(negedge clk);
    #20;
    if (reset_n && bus2.valid) begin
      if (q2.size() == 0) begin
        compared++; mismatched++;
        $display("FAIL unexpected_valid2: got valid=1 data=%b, required valid=0 at edge %0d", bus2.data, cyc);
      end else begin
        cur2 = q2.pop_front();
        check("valid_edge2", cyc, cur2.edge_n);
        check("data2", int'(bus2.data), int'(cur2.data));
      end
    end
  end

  // One scan of the main scanner; returns at the negedge before the handshake edge.
  task automatic do_scan(input logic [3:0] v, input int bp, input bit rnd,
                         input bit extra, input bit chain_next);
    int a, k, ph;
    @(negedge clk);
    if (chained) begin
      a = cyc;
    end else begin
      repeat ($urandom_range(0, 2)) @(negedge clk);
      bus.start = 1'b1;
      a = cyc + 1;
      @(negedge clk);
    end
    q1.push_back('{data: v, edge_n: a + SCAN});
    for (int t = 0; t < SCAN; t++) begin
      if (t > 0) @(negedge clk);
      k  = t / (S + 1);
      ph = t % (S + 1);
      check("scan_addr", int'(sel), k);
      check("scan_busy", int'(bus.busy), 1);
      if (t == 0) in_vec = v;
      bus.start = extra && ($urandom_range(0, 3) == 0);
      bus.ready = 1'($urandom_range(0, 1));
      if (rnd) begin
        for (int j = 0; j < k; j++)
          if ($urandom_range(0, 1) == 1) in_vec[j] = ~in_vec[j];
        if (ph == 0) in_vec[k] = ~v[k];
        else if (ph == 1) in_vec[k] = v[k];
      end
    end
    @(negedge clk);
    check("done_addr", int'(sel), 0);
    check("done_busy", int'(bus.busy), 0);
    for (int i = 0; i < bp; i++) begin
      bus.ready = 1'b0;
      bus.start = 1'($urandom_range(0, 1));
      @(negedge clk);
    end
    bus.ready = 1'b1;
    bus.start = chain_next;
    chained   = chain_next;
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish, required completion");
    $fatal(1);
  end

  initial begin
    int a;
    bus.start = 1'b0; bus.ready = 1'b0; bus2.start = 1'b0; bus2.ready = 1'b1;
    in_vec = '0; in2 = '0;
    #5 reset_n = 1'b0;
    #10;
    check("rst_addr0", int'(bus.address0), 0);
    check("rst_addr1", int'(bus.address1), 0);
    check("rst_data", int'(bus.data), 0);
    check("rst_valid", int'(bus.valid), 0);
    check("rst_busy", int'(bus.busy), 0);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;

    do_scan(4'b1010, 0, 1'b0, 1'b0, 1'b0);
    do_scan(4'b1010, 5, 1'b0, 1'b0, 1'b0);
    do_scan(4'b1010, 0, 1'b0, 1'b0, 1'b1);
    do_scan(4'b0101, 0, 1'b0, 1'b0, 1'b0);
    do_scan(4'b1010, 0, 1'b1, 1'b1, 1'b0);
    for (int n = 0; n < 30; n++)
      do_scan(4'($urandom), $urandom_range(0, 4), 1'b1, 1'b1, 1'($urandom_range(0, 1)));
    do_scan(4'b1010, 0, 1'b0, 1'b0, 1'b0);

    // Abort a scan partway through with an asynchronous reset.
    @(negedge clk);
    bus.start = 1'b1;
    in_vec = 4'b0110;
    a = cyc + 1;
    @(negedge clk);
    bus.start = 1'b0;
    while (cyc < a + 7) @(negedge clk);
    #10 reset_n = 1'b0;
    #10;
    check("mid_rst_addr0", int'(bus.address0), 0);
    check("mid_rst_addr1", int'(bus.address1), 0);
    check("mid_rst_data", int'(bus.data), 0);
    check("mid_rst_valid", int'(bus.valid), 0);
    check("mid_rst_busy", int'(bus.busy), 0);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    repeat (SCAN + 8) @(negedge clk);
    check("post_rst_data", int'(bus.data), 0);
    check("post_rst_busy", int'(bus.busy), 0);

    // Short settle time against the delayed mux.
    for (int n = 0; n < 6; n++) begin
      @(negedge clk);
      in2 = 4'($urandom);
      bus2.start = 1'b1;
      a = cyc + 1;
      q2.push_back('{data: in2, edge_n: a + SCAN2});
      @(negedge clk);
      bus2.start = 1'b0;
      repeat (SCAN2 + 2) @(negedge clk);
    end

    repeat (4) @(negedge clk);
    check("q1_drained", q1.size(), 0);
    check("q2_drained", q2.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
